memory_write_splitter: RTL and testbench
========================================

// Module: memory_write_splitter
// PURPOSE
// - Upstream feeder of the memory write interface: accepts one write request
//   (byte address + byte length) and issues it as a sequence of chunks on a
//   memory write interface master, one start/done handshake per chunk.
// - Chunks never exceed MAX_CHUNK bytes and never cross a BOUNDARY-aligned
//   address. Reports one completion pulse per request with sticky error status.
// PARAMETERS
// - ADDR_WIDTH  32    byte address width
// - LEN_WIDTH   16    byte length width, request and chunk
// - MAX_CHUNK   256   max bytes per chunk; power of 2, <= BOUNDARY
// - BOUNDARY    4096  chunks must not cross a multiple of this; power of 2
// PORTS
// - clock        in   1           single clock, rising edge
// - resetn       in   1           asynchronous active-low reset
// - req_addr     in   ADDR_WIDTH  request start byte address
// - req_len      in   LEN_WIDTH   request byte count; 0 is legal
// - req_valid    in   1           request present
// - req_ready    out  1           high only in IDLE; accept when valid&ready
// - cmp_done     out  1           one-cycle pulse: request finished or aborted
// - cmp_error    out  1           valid with cmp_done; any chunk reported error
// - busy         out  1           high from accept until the cmp_done cycle
// - mw_addr      out  ADDR_WIDTH  chunk address to memory write interface
// - mw_len       out  LEN_WIDTH   chunk byte count, never 0
// - mw_start     out  1           one-cycle chunk start pulse
// - mw_busy      in   1           write engine busy
// - mw_done      in   1           one-cycle chunk completion pulse
// - mw_error     in   1           sampled in the mw_done cycle
// BEHAVIOUR
// - Reset: req_ready=0 during reset then 1 in IDLE; cmp_done=0, cmp_error=0,
//   busy=0, mw_start=0, mw_addr=0, mw_len=0. State IDLE; held error cleared.
// - IDLE: on req_valid&req_ready latch cur_addr=req_addr, remaining=req_len,
//   clear err; goto ISSUE; if req_len==0 goto FINISH (no mw_start).
// - ISSUE: chunk = min(remaining, MAX_CHUNK, BOUNDARY - cur_addr%BOUNDARY).
//   Wait while mw_busy=1. When mw_busy=0: mw_start=1 for exactly one cycle,
//   mw_addr/mw_len registered and stable from that cycle until mw_done;
//   goto WAIT. Earliest mw_start: 1 cycle after accept.
// - WAIT: ignore until mw_done=1. Then cur_addr+=chunk, remaining-=chunk,
//   err|=mw_error. If mw_error or remaining==0 goto FINISH, else ISSUE.
//   mw_done in the same cycle as mw_start is not expected; ignored.
// - FINISH: cmp_done=1 one cycle, cmp_error=err; goto IDLE (req_ready=1 the
//   next cycle). Back-to-back requests: one idle cycle between.
// - Error: first chunk with mw_error aborts the request; no further chunks.
// - Arithmetic: addr add wraps modulo 2^ADDR_WIDTH; boundary math uses low
//   log2(BOUNDARY) address bits; all chunk sizes fit in LEN_WIDTH.
// - Reset asserted mid-request: immediate return to IDLE, no cmp_done, any
//   outstanding mw_done after reset release is ignored in IDLE.
// - mw_done/mw_error outside WAIT: ignored.
// TESTING
// - addr=0x1000,len=0 -> no mw_start; cmp_done 2 cycles after accept, err=0.
// - addr=0x2000,len=600 -> chunks (0x2000,256),(0x2100,256),(0x2200,88);
//   cmp_done once, cmp_error=0.
// - addr=0x0FF0,len=64 -> chunks (0x0FF0,16),(0x1000,48); none crosses 4 KiB.
// - len=768, mw_error=1 on 2nd mw_done -> exactly 2 mw_start, cmp_error=1.
// - mw_busy held 5 cycles before ISSUE -> mw_start delayed until mw_busy=0,
//   addr/len stable until mw_done.
// - resetn low during WAIT of 2nd chunk -> all outputs 0, IDLE; late mw_done
//   ignored; next request len=16 completes normally.

Source files
------------

// File: rtl/memory_write_splitter.sv
// Splits one byte-addressed write request into chunks of at most MAX_CHUNK bytes
// that never cross a BOUNDARY-aligned address, one start/done handshake per chunk.
module memory_write_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_CHUNK  = 256,
  parameter int BOUNDARY   = 4096
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  cmp_done,
  output logic                  cmp_error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mw_addr,
  output logic [LEN_WIDTH-1:0]  mw_len,
  output logic                  mw_start,
  input  logic                  mw_busy,
  input  logic                  mw_done,
  input  logic                  mw_error,
  output logic [1:0]            dbg_state
);

  localparam int LOG_B = $clog2(BOUNDARY);
  localparam int CW    = (LEN_WIDTH > LOG_B + 1) ? LEN_WIDTH : LOG_B + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  nxt_rem;
  logic [LEN_WIDTH-1:0]  src_rem;
  logic [LEN_WIDTH-1:0]  chunk;
  logic                  err;
  logic                  ready_q;
  logic                  accept;
  logic                  load_chunk;

  // Largest legal chunk at address a with r bytes left: bounded by r, MAX_CHUNK
  // and the distance to the next BOUNDARY multiple (low address bits only).
  function automatic logic [LEN_WIDTH-1:0] chunk_len(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [LEN_WIDTH-1:0]  r);
    logic [CW-1:0] to_bnd;
    logic [CW-1:0] lim;
    logic [CW-1:0] rem_w;
    to_bnd = CW'(BOUNDARY) - CW'(a[LOG_B-1:0]);
    lim    = (to_bnd < CW'(MAX_CHUNK)) ? to_bnd : CW'(MAX_CHUNK);
    rem_w  = CW'(r);
    return (rem_w < lim) ? LEN_WIDTH'(rem_w) : LEN_WIDTH'(lim);
  endfunction

  // Request handshake: a request transfers on a rising clock edge where
  // req_valid && req_ready; req_addr/req_len are sampled only on that edge.
  assign accept    = req_valid && ready_q && (state == S_IDLE);
  assign req_ready = ready_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // mw_len holds the chunk in flight, so the WAIT update uses it directly.
  assign nxt_addr = cur_addr + ADDR_WIDTH'(mw_len);
  assign nxt_rem  = remaining - mw_len;
  assign src_addr = (state == S_IDLE) ? req_addr : nxt_addr;
  assign src_rem  = (state == S_IDLE) ? req_len  : nxt_rem;
  assign chunk    = chunk_len(src_addr, src_rem);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mw_start   = 1'b0;
    cmp_done   = 1'b0;
    cmp_error  = 1'b0;
    load_chunk = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = S_ISSUE;
          load_chunk = (req_len != '0);
        end
      end
      S_ISSUE: begin
        // A zero-length request passes through here without issuing a chunk.
        if (remaining == '0) begin
          next_state = S_FINISH;
        end else if (!mw_busy) begin
          mw_start   = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mw_done) begin
          if (mw_error || (nxt_rem == '0)) begin
            next_state = S_FINISH;
          end else begin
            next_state = S_ISSUE;
            load_chunk = 1'b1;
          end
        end
      end
      S_FINISH: begin
        cmp_done   = 1'b1;
        cmp_error  = err;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_addr  <= '0;
      remaining <= '0;
      err       <= 1'b0;
      mw_addr   <= '0;
      mw_len    <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= (next_state == S_IDLE);
      if (accept) begin
        cur_addr  <= req_addr;
        remaining <= req_len;
        err       <= 1'b0;
      end else if ((state == S_WAIT) && mw_done) begin
        cur_addr  <= nxt_addr;
        remaining <= nxt_rem;
        err       <= err | mw_error;
      end
      if (load_chunk) begin
        mw_addr <= src_addr;
        mw_len  <= chunk;
      end
    end
  end

endmodule

// File: tb/tb_memory_write_splitter.sv
// Bench for memory_write_splitter: directed scenarios plus randomized requests,
// with expected chunk lists computed arithmetically from address and length.
module tb_memory_write_splitter;

  localparam int MAX_CHUNK = 256;
  localparam int BOUNDARY  = 4096;

  logic        clock;
  logic        resetn;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        req_valid;
  logic        req_ready;
  logic        cmp_done;
  logic        cmp_error;
  logic        busy;
  logic [31:0] mw_addr;
  logic [15:0] mw_len;
  logic        mw_start;
  logic        mw_busy;
  logic        mw_done;
  logic        mw_error;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [47:0] exp_q[$];

  memory_write_splitter #(
    .ADDR_WIDTH(32), .LEN_WIDTH(16), .MAX_CHUNK(MAX_CHUNK), .BOUNDARY(BOUNDARY)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .cmp_done(cmp_done), .cmp_error(cmp_error), .busy(busy),
    .mw_addr(mw_addr), .mw_len(mw_len), .mw_start(mw_start),
    .mw_busy(mw_busy), .mw_done(mw_done), .mw_error(mw_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_outputs_zero(input string phase);
    check_eq({phase, "_req_ready"}, req_ready, 0);
    check_eq({phase, "_cmp_done"},  cmp_done,  0);
    check_eq({phase, "_cmp_error"}, cmp_error, 0);
    check_eq({phase, "_busy"},      busy,      0);
    check_eq({phase, "_mw_start"},  mw_start,  0);
    check_eq({phase, "_mw_addr"},   mw_addr,   0);
    check_eq({phase, "_mw_len"},    mw_len,    0);
  endtask

  // Reset asserted while a chunk is outstanding, followed by a stray mw_done.
  task automatic mid_reset();
    logic bad;
    bad = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b0; mw_done = 1'b0; mw_busy = 1'b0;
    @(negedge clock);
    check_outputs_zero("midrst");
    @(posedge clock); #1;
    resetn = 1'b1; mw_done = 1'b1; mw_error = 1'b1;
    @(posedge clock); #1;
    mw_done = 1'b0; mw_error = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (cmp_done || mw_start || busy) bad = 1'b1;
    end
    check_eq("late_done_ignored", bad, 0);
    check_eq("ready_after_midrst", req_ready, 1);
  endtask

  // driver + engine model: issues one request and plays the write engine.
  // err_idx: 1-based chunk that reports mw_error (0 = none); pre_busy: cycles of
  // mw_busy after accept; rst_after: reset after that many chunk starts (0 = never).
  task automatic run_req(input logic [31:0] addr, input logic [15:0] len,
                         input int err_idx, input int pre_busy, input int rst_after);
    longint unsigned a;
    int r, c, n_exp, starts, cyc, wait_n, pre_cnt, first_start, last_done, done_cyc;
    logic exp_err, pending, done_seen, got_err, bad_busy, bad_stable, start_busy;
    logic [31:0] cur_a;
    logic [15:0] cur_l;
    logic [47:0] e;

    // reference model: walk the request in legal chunks
    exp_q.delete();
    a = addr;
    r = len;
    while (r > 0) begin
      c = (r < MAX_CHUNK) ? r : MAX_CHUNK;
      if (c > BOUNDARY - int'(a % BOUNDARY)) c = BOUNDARY - int'(a % BOUNDARY);
      exp_q.push_back({a[31:0], c[15:0]});
      a = (a + longint'(c)) % 64'h1_0000_0000;
      r -= c;
    end
    exp_err = 1'b0;
    if (err_idx > 0 && err_idx <= exp_q.size()) begin
      while (exp_q.size() > err_idx) void'(exp_q.pop_back());
      exp_err = 1'b1;
    end
    n_exp = exp_q.size();

    starts = 0; first_start = 0; last_done = 0; done_cyc = 0; wait_n = 0;
    pending = 0; done_seen = 0; got_err = 0; bad_busy = 0; bad_stable = 0; start_busy = 0;
    cur_a = '0; cur_l = '0;

    @(negedge clock);
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("req_ready", req_ready, 1);
    req_addr = addr; req_len = len; req_valid = 1'b1;
    mw_busy = (pre_busy > 0);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_len = 16'($urandom);
    pre_cnt = pre_busy;
    cyc = 0;
    while (!done_seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (!busy) bad_busy = 1'b1;
      if (mw_start) begin
        starts++;
        if (mw_busy) start_busy = 1'b1;
        if (starts == 1) first_start = cyc;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("chunk_addr", mw_addr, e[47:16]);
          check_eq("chunk_len", mw_len, e[15:0]);
        end else begin
          check_eq("extra_chunk", starts, n_exp);
        end
        pending = 1'b1; cur_a = mw_addr; cur_l = mw_len;
        wait_n = $urandom_range(1, 4);
        if (starts == rst_after) begin
          mid_reset();
          return;
        end
      end else if (pending && (mw_addr !== cur_a || mw_len !== cur_l)) begin
        bad_stable = 1'b1;
      end
      if (cmp_done) begin
        done_seen = 1'b1; got_err = cmp_error; done_cyc = cyc;
      end
      @(posedge clock); #1;
      mw_done = 1'b0;
      mw_error = 1'($urandom);
      if (pending) begin
        wait_n--;
        if (wait_n == 0) begin
          mw_done = 1'b1;
          mw_error = (starts == err_idx);
          pending = 1'b0;
          last_done = cyc + 1;
        end
      end
      if (pre_cnt > 0) pre_cnt--;
      mw_busy = (pre_cnt > 0) || pending;
    end

    check_eq("cmp_done_seen", done_seen, 1);
    check_eq("chunk_count", starts, n_exp);
    check_eq("cmp_error", got_err, exp_err);
    if (n_exp > 0) begin
      check_eq("first_start_cycle", first_start, pre_busy + 1);
      check_eq("done_latency", done_cyc, last_done + 1);
    end else begin
      check_eq("zero_len_done_cycle", done_cyc, 2);
    end
    check_eq("busy_held", bad_busy, 0);
    check_eq("chunk_stable", bad_stable, 0);
    check_eq("start_while_busy", start_busy, 0);
    @(negedge clock);
    check_eq("done_one_cycle", cmp_done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", req_ready, 1);
    mw_busy = 1'b0; mw_done = 1'b0; mw_error = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rl;
    resetn = 1'b0; req_addr = '0; req_len = '0; req_valid = 1'b0;
    mw_busy = 1'b0; mw_done = 1'b0; mw_error = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("ready_after_reset", req_ready, 1);
    check_eq("idle_after_reset", busy, 0);

    run_req(32'h0000_1000, 16'd0,   0, 0, 0);
    run_req(32'h0000_2000, 16'd600, 0, 0, 0);
    run_req(32'h0000_0FF0, 16'd64,  0, 0, 0);
    run_req(32'h0000_3000, 16'd768, 2, 0, 0);
    run_req(32'h0000_4000, 16'd300, 0, 5, 0);
    run_req(32'h0000_5000, 16'd768, 0, 0, 2);
    run_req(32'h0000_6000, 16'd16,  0, 0, 0);
    run_req(32'hFFFF_FF80, 16'd300, 0, 0, 0);
    run_req(32'h0000_7F00, 16'd1,   1, 0, 0);

    repeat (24) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = (ra & 32'hFFFF_F000) | 32'(12'hF00 + $urandom_range(0, 255));
      rl = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1100));
      run_req(ra, rl, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
